// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm match detection, ring/snooze/timeout control and buzzer drive
// Optional feature macro: ALARM_SNOOZE_EN (defined: snooze state, target latch, snooze outputs).
// Ports:
//   clk_50M, rst               clock, asynchronous active-high reset
//   state_mode, alarm_en       UI mode (4'd3 = alarm setting), alarm armed level
//   hour/minute/second_time    running clock time, binary
//   alarm_*_time               stored alarm time, binary
//   stop_key, snooze_key       raw active-low keys
//   buzzer                     gated square-wave drive
//   alarm_active, snoozing     RINGING / SNOOZE flags
//   snooze_count               snoozes used in the current alarm event
module alarm_ringer #(
  parameter int TONE_HALF      = 12500,
  parameter int GATE_HALF      = 12500000,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [3:0] state_mode,
  input  logic       alarm_en,
  input  logic [7:0] hour_time,
  input  logic [7:0] minute_time,
  input  logic [7:0] second_time,
  input  logic [7:0] alarm_hour_time,
  input  logic [7:0] alarm_minute_time,
  input  logic [7:0] alarm_second_time,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic       buzzer,
  output logic       alarm_active,
  output logic       snoozing,
  output logic [1:0] snooze_count
);
  localparam int TW = $clog2(TONE_HALF + 1);
  localparam int GW = $clog2(GATE_HALF + 1);
  localparam int RW = $clog2(RING_SECONDS + 1);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RINGING = 2'd1, S_SNOOZE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RINGING = 2'd1} state_t;
`endif

  state_t        r_state, w_state_nx;
  logic          r_stop_buf0, r_stop_buf1;
  logic          r_match_prev;
  logic [7:0]    r_sec_prev;
  logic [RW-1:0] r_ring_sec, w_ring_sec_nx;
  logic [TW-1:0] r_tone_cnt, w_tone_cnt_nx;
  logic [GW-1:0] r_gate_cnt, w_gate_cnt_nx;
  logic          r_tone, w_tone_nx, r_gate, w_gate_nx;
  logic          r_buzzer, r_alarm_active;
  logic          w_stop_press, w_match, w_trigger, w_sec_tick;

  assign w_stop_press = ~r_stop_buf0 & r_stop_buf1;
  assign w_match = alarm_en && (state_mode != 4'd3) && (hour_time == alarm_hour_time) &&
                   (minute_time == alarm_minute_time) && (second_time == alarm_second_time);
  // Only the first matching cycle fires, so a held match does not re-trigger after stop.
  assign w_trigger  = w_match & ~r_match_prev;
  assign w_sec_tick = (second_time != r_sec_prev);
  assign buzzer       = r_buzzer;
  assign alarm_active = r_alarm_active;

`ifdef ALARM_SNOOZE_EN
  logic       r_snz_buf0, r_snz_buf1, r_smatch_prev, r_snoozing;
  logic [1:0] r_count, w_count_nx;
  logic [7:0] r_tgt_hour, r_tgt_min, w_tgt_hour_nx, w_tgt_min_nx;
  logic [7:0] w_min_sum;
  logic       w_snooze_press, w_smatch, w_snz_trigger;

  assign w_snooze_press = ~r_snz_buf0 & r_snz_buf1;
  assign w_min_sum      = minute_time + 8'(SNOOZE_MINUTES);
  // Resume compares against the latched target, with the stored alarm second.
  assign w_smatch = (hour_time == r_tgt_hour) && (minute_time == r_tgt_min) &&
                    (second_time == alarm_second_time);
  assign w_snz_trigger = w_smatch & ~r_smatch_prev;
  assign snoozing      = r_snoozing;
  assign snooze_count  = r_count;
`else
  logic w_unused_snooze_key;
  assign w_unused_snooze_key = snooze_key;
  assign snoozing     = 1'b0;
  assign snooze_count = 2'd0;
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_ring_sec_nx = r_ring_sec;
    w_tone_cnt_nx = r_tone_cnt;
    w_gate_cnt_nx = r_gate_cnt;
    w_tone_nx     = r_tone;
    w_gate_nx     = r_gate;
`ifdef ALARM_SNOOZE_EN
    w_count_nx    = r_count;
    w_tgt_hour_nx = r_tgt_hour;
    w_tgt_min_nx  = r_tgt_min;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_nx    = S_RINGING;
          w_ring_sec_nx = '0;
        end
      end
      S_RINGING: begin
        if (!alarm_en || w_stop_press) begin
          w_state_nx = S_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (w_snooze_press && (r_count < 2'(MAX_SNOOZE))) begin
          w_state_nx = S_SNOOZE;
          w_count_nx = r_count + 2'd1;
          if (w_min_sum >= 8'd60) begin
            w_tgt_min_nx  = w_min_sum - 8'd60;
            w_tgt_hour_nx = (hour_time == 8'd23) ? 8'd0 : hour_time + 8'd1;
          end else begin
            w_tgt_min_nx  = w_min_sum;
            w_tgt_hour_nx = hour_time;
          end
`endif
        end else if (w_sec_tick) begin
          if (r_ring_sec == RW'(RING_SECONDS - 1)) w_state_nx = S_IDLE;
          else w_ring_sec_nx = r_ring_sec + RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (!alarm_en || w_stop_press) begin
          w_state_nx = S_IDLE;
        end else if (w_snz_trigger) begin
          w_state_nx    = S_RINGING;
          w_ring_sec_nx = '0;
        end
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
`ifdef ALARM_SNOOZE_EN
    if (w_state_nx == S_IDLE) w_count_nx = 2'd0;
`endif
    // Tone/gate restart on every entry to RINGING so each ring starts in a gate-on window.
    if ((w_state_nx == S_RINGING) && (r_state != S_RINGING)) begin
      w_tone_cnt_nx = '0;
      w_gate_cnt_nx = '0;
      w_tone_nx     = 1'b0;
      w_gate_nx     = 1'b1;
    end else if (r_state == S_RINGING) begin
      if (r_tone_cnt == TW'(TONE_HALF - 1)) begin
        w_tone_cnt_nx = '0;
        w_tone_nx     = ~r_tone;
      end else begin
        w_tone_cnt_nx = r_tone_cnt + TW'(1);
      end
      if (r_gate_cnt == GW'(GATE_HALF - 1)) begin
        w_gate_cnt_nx = '0;
        w_gate_nx     = ~r_gate;
      end else begin
        w_gate_cnt_nx = r_gate_cnt + GW'(1);
      end
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_stop_buf0    <= 1'b1;
      r_stop_buf1    <= 1'b1;
      r_match_prev   <= 1'b1;
      r_sec_prev     <= 8'd0;
      r_ring_sec     <= '0;
      r_tone_cnt     <= '0;
      r_gate_cnt     <= '0;
      r_tone         <= 1'b0;
      r_gate         <= 1'b1;
      r_buzzer       <= 1'b0;
      r_alarm_active <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_stop_buf0    <= stop_key;
      r_stop_buf1    <= r_stop_buf0;
      r_match_prev   <= w_match;
      r_sec_prev     <= second_time;
      r_ring_sec     <= w_ring_sec_nx;
      r_tone_cnt     <= w_tone_cnt_nx;
      r_gate_cnt     <= w_gate_cnt_nx;
      r_tone         <= w_tone_nx;
      r_gate         <= w_gate_nx;
      r_buzzer       <= (w_state_nx == S_RINGING) & w_gate_nx & w_tone_nx;
      r_alarm_active <= (w_state_nx == S_RINGING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_snz_buf0    <= 1'b1;
      r_snz_buf1    <= 1'b1;
      r_smatch_prev <= 1'b1;
      r_snoozing    <= 1'b0;
      r_count       <= 2'd0;
      r_tgt_hour    <= 8'd0;
      r_tgt_min     <= 8'd0;
    end else begin
      r_snz_buf0    <= snooze_key;
      r_snz_buf1    <= r_snz_buf0;
      r_smatch_prev <= w_smatch;
      r_snoozing    <= (w_state_nx == S_SNOOZE);
      r_count       <= w_count_nx;
      r_tgt_hour    <= w_tgt_hour_nx;
      r_tgt_min     <= w_tgt_min_nx;
    end
  end
`endif

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - randomized scoreboard bench for alarm_ringer
module tb_alarm_ringer;
  localparam int TH = 2, GH = 8, RS = 3, SM = 5, MS = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  localparam int ST_IDLE = 0, ST_RING = 1, ST_SNZ = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_mode;
  logic       alarm_en;
  logic [7:0] hour_time, minute_time, second_time;
  logic [7:0] alarm_hour_time, alarm_minute_time, alarm_second_time;
  logic       stop_key, snooze_key;
  logic       buzzer, alarm_active, snoozing;
  logic [1:0] snooze_count;

  alarm_ringer #(.TONE_HALF(TH), .GATE_HALF(GH), .RING_SECONDS(RS),
                 .SNOOZE_MINUTES(SM), .MAX_SNOOZE(MS)) dut (
    .clk_50M(clk), .rst(rst), .state_mode(state_mode), .alarm_en(alarm_en),
    .hour_time(hour_time), .minute_time(minute_time), .second_time(second_time),
    .alarm_hour_time(alarm_hour_time), .alarm_minute_time(alarm_minute_time),
    .alarm_second_time(alarm_second_time), .stop_key(stop_key), .snooze_key(snooze_key),
    .buzzer(buzzer), .alarm_active(alarm_active), .snoozing(snoozing),
    .snooze_count(snooze_count));

  always #5 clk = ~clk;

  typedef struct { int cyc; bit act; bit snz; bit [1:0] cnt; bit buz; } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int tsec;

  // Reference model state
  int m_state, m_ring, m_cnt, m_k, m_tgt_h, m_tgt_m, m_sec_prev;
  bit m_prev_match, m_prev_smatch, m_stop_h1, m_stop_h2, m_snz_h1, m_snz_h2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (alarm_active !== e.act || snoozing !== e.snz || snooze_count !== e.cnt || buzzer !== e.buz) begin
        bad++;
        $display("FAIL outputs cyc=%0d act/snz/cnt/buz got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                 cyc, alarm_active, snoozing, snooze_count, buzzer, e.act, e.snz, e.cnt, e.buz);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic set_t(input int s);
    tsec = s % 86400;
    hour_time   = 8'(tsec / 3600);
    minute_time = 8'((tsec / 60) % 60);
    second_time = 8'(tsec % 60);
  endtask

  task automatic set_alarm(input int h, input int m, input int s);
    alarm_hour_time = 8'(h); alarm_minute_time = 8'(m); alarm_second_time = 8'(s);
  endtask

  function automatic int alarm_tod();
    return int'(alarm_hour_time) * 3600 + int'(alarm_minute_time) * 60 + int'(alarm_second_time);
  endfunction

  // Predict the outputs after the coming clock edge from the currently driven inputs.
  task automatic tick();
    bit stop_p, snz_p, match, trig, stick, smatch, strig, buz;
    int old, t;
    stop_p = !m_stop_h1 && m_stop_h2;
    snz_p  = !m_snz_h1 && m_snz_h2;
    match  = alarm_en && state_mode != 4'd3 && hour_time == alarm_hour_time &&
             minute_time == alarm_minute_time && second_time == alarm_second_time;
    trig   = match && !m_prev_match;
    stick  = int'(second_time) != m_sec_prev;
    smatch = int'(hour_time) == m_tgt_h && int'(minute_time) == m_tgt_m &&
             second_time == alarm_second_time;
    strig  = smatch && !m_prev_smatch;
    old = m_state;
    case (m_state)
      ST_IDLE: if (trig) begin m_state = ST_RING; m_ring = 0; m_cnt = 0; end
      ST_RING: begin
        if (!alarm_en || stop_p) m_state = ST_IDLE;
        else if (SNZ && snz_p && m_cnt < MS) begin
          m_state = ST_SNZ;
          m_cnt++;
          t = (int'(hour_time) * 60 + int'(minute_time) + SM) % 1440;
          m_tgt_h = t / 60;
          m_tgt_m = t % 60;
        end else if (stick) begin
          m_ring++;
          if (m_ring == RS) m_state = ST_IDLE;
        end
      end
      default: begin
        if (!alarm_en || stop_p) m_state = ST_IDLE;
        else if (strig) begin m_state = ST_RING; m_ring = 0; end
      end
    endcase
    if (m_state == ST_IDLE) m_cnt = 0;
    if (m_state == ST_RING) m_k = (old == ST_RING) ? m_k + 1 : 0;
    buz = (m_state == ST_RING) && ((m_k / GH) % 2 == 0) && ((m_k / TH) % 2 == 1);
    m_prev_match = match; m_prev_smatch = smatch; m_sec_prev = int'(second_time);
    m_stop_h2 = m_stop_h1; m_stop_h1 = stop_key;
    m_snz_h2 = m_snz_h1; m_snz_h1 = snooze_key;
    q.push_back('{cyc + 1, m_state == ST_RING, m_state == ST_SNZ, 2'(m_cnt), buz});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit stp, input bit snz, input int len);
    if (stp) stop_key = 1'b0;
    if (snz) snooze_key = 1'b0;
    run(len);
    stop_key = 1'b1;
    snooze_key = 1'b1;
    run($urandom_range(3, 6));
  endtask

  task automatic ring_now();
    set_t(alarm_tod() - 1 + 86400);
    run(3);
    set_t(alarm_tod());
    run($urandom_range(4, 12));
  endtask

  initial begin
    rst = 1'b1; state_mode = 4'd0; alarm_en = 1'b1;
    stop_key = 1'b1; snooze_key = 1'b1;
    set_t(0);
    set_alarm(7, 30, 0);
    m_state = ST_IDLE; m_ring = 0; m_cnt = 0; m_k = 0; m_tgt_h = 0; m_tgt_m = 0; m_sec_prev = 0;
    m_prev_match = 1; m_prev_smatch = 1; m_stop_h1 = 1; m_stop_h2 = 1; m_snz_h1 = 1; m_snz_h2 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_alarm_active", int'(alarm_active), 0);
    chk("reset_buzzer", int'(buzzer), 0);
    chk("reset_snoozing", int'(snoozing), 0);
    chk("reset_snooze_count", int'(snooze_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Trigger, buzzer pattern, then timeout after three second changes
    set_t(7 * 3600 + 29 * 60 + 59); run(5);
    set_t(tsec + 1); run(40);
    for (int i = 0; i < 3; i++) begin set_t(tsec + 1); run($urandom_range(4, 12)); end
    run(6);

    // Stop, then stop and snooze together
    ring_now(); press(1'b1, 1'b0, $urandom_range(1, 3));
    ring_now(); press(1'b1, 1'b1, 2);

    // Blocked triggers: alarm-setting mode, alarm disarmed; then disarm mid-ring
    set_t(alarm_tod() - 5); run(3);
    state_mode = 4'd3; set_t(alarm_tod()); run(10);
    set_t(alarm_tod() + 5); run(2); state_mode = 4'd0; run(2);
    alarm_en = 1'b0; set_t(alarm_tod()); run(10);
    set_t(alarm_tod() + 5); run(2); alarm_en = 1'b1; run(2);
    ring_now(); alarm_en = 1'b0; run(3); alarm_en = 1'b1; run(3);

    // Snooze across midnight, resume, exhaust snoozes, extra press ignored
    set_alarm(23, 57, 0);
    ring_now();
    set_t(23 * 3600 + 57 * 60 + 10); run(3);
    press(1'b0, 1'b1, 2);
    set_alarm(12, 34, 0); run(4);
    set_t(0 * 3600 + 1 * 60 + 59); run(4);
    set_t(2 * 60); run(6);
    for (int j = 0; j < 3; j++) begin
      press(1'b0, 1'b1, $urandom_range(1, 3));
      set_t(((tsec / 60) * 60 + SM * 60) - 1); run(3);
      set_t(tsec + 1); run(5);
    end
    press(1'b0, 1'b1, 2);
    run(8);
    press(1'b1, 1'b0, 2);

    // Random soup around a random alarm time
    set_alarm($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
    set_t(alarm_tod() + 86400 - 2);
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 99);
      stop_key   = ($urandom_range(0, 11) != 0);
      snooze_key = ($urandom_range(0, 4) != 0);
      alarm_en   = ($urandom_range(0, 59) != 0);
      state_mode = ($urandom_range(0, 29) == 0) ? 4'd3 : 4'd0;
      if (r < 60) set_t(tsec + 1);
      else if (r < 75) set_t(alarm_tod() + 86400 - $urandom_range(0, 2));
      else if (r < 85) set_t(m_tgt_h * 3600 + m_tgt_m * 60 + int'(alarm_second_time) + 86400 - $urandom_range(0, 1));
      run($urandom_range(1, 4));
    end
    stop_key = 1'b1; snooze_key = 1'b1; alarm_en = 1'b1; state_mode = 4'd0;
    run(6);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
